micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
Micro-program counter sequencer that consumes the micro-jump ROM output. It holds the micro-PC (uPC) that addresses the microcode ROM and selects the next uPC each cycle from the current micro-instruction's next-address field. The sources are increment, dispatch, jump, conditional branch, call/return, memory wait and return-to-fetch. It sits between the microcode ROM output and the micro-jump ROM output, and drives the microcode ROM address.

Parameters:
UPC_WIDTH, 8, uPC width; equals log2 of the microcode ROM size.
STACK_DEPTH, 2, micro-return stack entries (>=1).
FETCH_ADDR, 0, uPC of the instruction-fetch micro-routine.
EXC_ADDR, 8'hF0, uPC of the micro-exception routine.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
next_sel  in  3  next-address op from the current micro-instruction.
u_target  in  UPC_WIDTH  jump/branch/call target from the micro-instruction.
cond_in  in  1  branch condition (ALU compare result).
dispatch_addr  in  UPC_WIDTH  micro-jump ROM output for the current RISC-V instruction.
mem_ready  in  1  data/instruction memory handshake complete.
exc_req  in  1  exception request; overrides next_sel.
stall  in  1  freeze sequencer.
upc  out  UPC_WIDTH  current uPC (registered).
sp_count  out  $clog2(STACK_DEPTH+1)  occupied stack entries.
stack_err  out  1  sticky stack overflow/underflow flag.
retire  out  1  one-cycle pulse, registered, set when a FETCH op was executed.

Behaviour:
- Reset values: upc=FETCH_ADDR, sp_count=0, stack_err=0, retire=0, stack contents don't-care.
- All state updates on the rising edge of clk. Outputs are registered; there is no combinational path from inputs to outputs.
- Update priority: reset > exc_req > stall > next_sel.
- exc_req=1: upc<=EXC_ADDR, sp_count<=0, retire<=0.
- stall=1 (no exc_req): all state holds, retire<=0.
- next_sel encoding:
  - 0 SEQ: upc<=upc+1.
  - 1 DISPATCH: upc<=dispatch_addr.
  - 2 JUMP: upc<=u_target.
  - 3 BRANCH: upc<= cond_in ? u_target : upc+1.
  - 4 CALL: if sp_count<STACK_DEPTH, push upc+1 and set upc<=u_target. Else overflow: stack_err<=1, upc<=EXC_ADDR, sp_count unchanged.
  - 5 RET: if sp_count>0, pop and set upc<=popped value. Else underflow: stack_err<=1, upc<=EXC_ADDR.
  - 6 WAIT: if mem_ready, upc<=upc+1; else upc holds. There is no timeout.
  - 7 FETCH: upc<=FETCH_ADDR, retire<=1.
- retire is 0 in every cycle that did not execute FETCH.
- upc+1 wraps modulo 2^UPC_WIDTH; max value +1 gives 0.
- The stack is LIFO, with the top at index sp_count-1.
- stack_err stays set until reset; exc_req does not clear it.
- In the CALL push, the value pushed is upc+1 computed before the update.
- reset asserted mid-WAIT or mid-call nest: the next cycle is the full reset state, with the stack emptied.

Test Plan:
- reset held 2 cycles, then next_sel=0 for 3 cycles -> upc 0,1,2,3; retire=0; sp_count=0.
- upc=5, next_sel=1, dispatch_addr=8'h40 -> upc=8'h40 next cycle. Then next_sel=7 -> upc=0, retire=1 for exactly one cycle.
- upc=8'h10: next_sel=3, cond_in=0 -> 8'h11. Then next_sel=3, cond_in=1, u_target=8'h30 -> 8'h30.
- STACK_DEPTH=2, start at upc=8'h20: CALL to 8'h50 (push 8'h21), CALL to 8'h60 (push 8'h51), CALL again -> upc=EXC_ADDR, stack_err=1, sp_count=2. After a reset on the same run: RET, RET, RET -> underflow, upc=EXC_ADDR, stack_err=1.
- upc=8'h12, next_sel=6 with mem_ready=0 for 4 cycles -> upc stays 8'h12. mem_ready=1 -> upc=8'h13. During the wait, stall=1 with exc_req=1 in the same cycle -> upc=EXC_ADDR.
- upc=8'hFF, next_sel=0 -> upc=0, retire=0.

Source files
------------

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: selects the next microcode ROM address from the
// current micro-instruction's next-address op, with a small return stack.
module micro_sequencer #(
    parameter int                   UPC_WIDTH   = 8,
    parameter int                   STACK_DEPTH = 2,
    parameter logic [UPC_WIDTH-1:0] FETCH_ADDR  = '0,
    parameter logic [UPC_WIDTH-1:0] EXC_ADDR    = 8'hF0,
    localparam int                  SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           next_sel,
    input  logic [UPC_WIDTH-1:0] u_target,
    input  logic                 cond_in,
    input  logic [UPC_WIDTH-1:0] dispatch_addr,
    input  logic                 mem_ready,
    input  logic                 exc_req,
    input  logic                 stall,
    output logic [UPC_WIDTH-1:0] upc,
    output logic [SPW-1:0]       sp_count,
    output logic                 stack_err,
    output logic                 retire
);

    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] DEPTH_C = SPW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ      = 3'd0,
        OP_DISPATCH = 3'd1,
        OP_JUMP     = 3'd2,
        OP_BRANCH   = 3'd3,
        OP_CALL     = 3'd4,
        OP_RET      = 3'd5,
        OP_WAIT     = 3'd6,
        OP_FETCH    = 3'd7
    } op_e;

    logic [UPC_WIDTH-1:0] upc_q, upc_d;
    logic [SPW-1:0]       sp_q, sp_d;
    logic                 err_q, err_d;
    logic                 retire_q, retire_d;
    logic                 push_en;
    logic [UPC_WIDTH-1:0] upc_inc;
    logic [IDXW-1:0]      push_idx, pop_idx;
    logic [UPC_WIDTH-1:0] stack_q [STACK_DEPTH];
    op_e                  op;

    assign op       = op_e'(next_sel);
    assign upc_inc  = upc_q + UPC_WIDTH'(1);
    assign push_idx = IDXW'(sp_q);
    assign pop_idx  = IDXW'(sp_q - SPW'(1));

    always_comb begin
        upc_d    = upc_q;
        sp_d     = sp_q;
        err_d    = err_q;
        retire_d = 1'b0;
        push_en  = 1'b0;
        if (exc_req) begin
            upc_d = EXC_ADDR;
            sp_d  = '0;
        end else if (!stall) begin
            case (op)
                OP_SEQ:      upc_d = upc_inc;
                OP_DISPATCH: upc_d = dispatch_addr;
                OP_JUMP:     upc_d = u_target;
                OP_BRANCH:   upc_d = cond_in ? u_target : upc_inc;
                OP_CALL: begin
                    if (sp_q < DEPTH_C) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SPW'(1);
                        upc_d   = u_target;
                    end else begin
                        err_d = 1'b1;
                        upc_d = EXC_ADDR;
                    end
                end
                OP_RET: begin
                    if (sp_q != '0) begin
                        sp_d  = sp_q - SPW'(1);
                        upc_d = stack_q[pop_idx];
                    end else begin
                        err_d = 1'b1;
                        upc_d = EXC_ADDR;
                    end
                end
                OP_WAIT:  upc_d = mem_ready ? upc_inc : upc_q;
                OP_FETCH: begin
                    upc_d    = FETCH_ADDR;
                    retire_d = 1'b1;
                end
                default: upc_d = upc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q    <= FETCH_ADDR;
            sp_q     <= '0;
            err_q    <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            upc_q    <= upc_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            retire_q <= retire_d;
        end
    end

    // Stack contents need no reset; sp_q alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push_en) begin
            stack_q[push_idx] <= upc_inc;
        end
    end

    assign upc       = upc_q;
    assign sp_count  = sp_q;
    assign stack_err = err_q;
    assign retire    = retire_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: driver queues hand-computed
// expected state, a monitor pops and compares after each rising edge.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] next_sel = '0;
    logic [7:0] u_target = '0;
    logic       cond_in = 1'b0;
    logic [7:0] dispatch_addr = '0;
    logic       mem_ready = 1'b0;
    logic       exc_req = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] upc;
    logic [1:0] sp_count;
    logic       stack_err;
    logic       retire;

    typedef struct packed {
        logic [7:0] upc;
        logic [1:0] sp;
        logic       err;
        logic       ret;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;

    micro_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .next_sel      (next_sel),
        .u_target      (u_target),
        .cond_in       (cond_in),
        .dispatch_addr (dispatch_addr),
        .mem_ready     (mem_ready),
        .exc_req       (exc_req),
        .stall         (stall),
        .upc           (upc),
        .sp_count      (sp_count),
        .stack_err     (stack_err),
        .retire        (retire)
    );

    always #5 clk = ~clk;

    // Monitor: each queued entry describes the state after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (upc !== e.upc || sp_count !== e.sp ||
                    stack_err !== e.err || retire !== e.ret) begin
                    n_bad++;
                    $display("FAIL step%0d: got upc=%h sp=%0d err=%b ret=%b, want upc=%h sp=%0d err=%b ret=%b",
                             n_cmp, upc, sp_count, stack_err, retire,
                             e.upc, e.sp, e.err, e.ret);
                end
            end
        end
    end

    task automatic step(
        input logic [2:0] sel,
        input logic [7:0] eu,
        input logic [1:0] es,
        input logic       ee,
        input logic       er,
        input logic [7:0] tgt = 8'h00,
        input logic       cnd = 1'b0,
        input logic [7:0] dsp = 8'h00,
        input logic       mr  = 1'b0,
        input logic       ex  = 1'b0,
        input logic       st  = 1'b0,
        input logic       rs  = 1'b0
    );
        exp_t e;
        @(negedge clk);
        next_sel      = sel;
        u_target      = tgt;
        cond_in       = cnd;
        dispatch_addr = dsp;
        mem_ready     = mr;
        exc_req       = ex;
        stall         = st;
        reset         = rs;
        e.upc = eu;
        e.sp  = es;
        e.err = ee;
        e.ret = er;
        q.push_back(e);
        n_step++;
    endtask

    initial begin
        int budget;
        // reset held two cycles, then SEQ
        step(3'd0, 8'h00, 2'd0, 1'b0, 1'b0, .rs(1'b1));
        step(3'd0, 8'h00, 2'd0, 1'b0, 1'b0, .rs(1'b1));
        step(3'd0, 8'h01, 2'd0, 1'b0, 1'b0);
        step(3'd0, 8'h02, 2'd0, 1'b0, 1'b0);
        step(3'd0, 8'h03, 2'd0, 1'b0, 1'b0);
        step(3'd0, 8'h04, 2'd0, 1'b0, 1'b0);
        step(3'd0, 8'h05, 2'd0, 1'b0, 1'b0);
        // dispatch then fetch; retire pulses one cycle
        step(3'd1, 8'h40, 2'd0, 1'b0, 1'b0, .dsp(8'h40));
        step(3'd7, 8'h00, 2'd0, 1'b0, 1'b1);
        step(3'd0, 8'h01, 2'd0, 1'b0, 1'b0);
        // branch not taken / taken
        step(3'd2, 8'h10, 2'd0, 1'b0, 1'b0, .tgt(8'h10));
        step(3'd3, 8'h11, 2'd0, 1'b0, 1'b0, .tgt(8'h77), .cnd(1'b0));
        step(3'd3, 8'h30, 2'd0, 1'b0, 1'b0, .tgt(8'h30), .cnd(1'b1));
        // call nest to overflow
        step(3'd2, 8'h20, 2'd0, 1'b0, 1'b0, .tgt(8'h20));
        step(3'd4, 8'h50, 2'd1, 1'b0, 1'b0, .tgt(8'h50));
        step(3'd4, 8'h60, 2'd2, 1'b0, 1'b0, .tgt(8'h60));
        step(3'd4, 8'hF0, 2'd2, 1'b1, 1'b0, .tgt(8'h70));
        // stall holds; exc clears sp but not stack_err
        step(3'd0, 8'hF0, 2'd2, 1'b1, 1'b0, .st(1'b1));
        step(3'd0, 8'hF0, 2'd0, 1'b1, 1'b0, .ex(1'b1));
        step(3'd0, 8'h00, 2'd0, 1'b0, 1'b0, .rs(1'b1));
        // call then return in LIFO order, then underflow
        step(3'd2, 8'h20, 2'd0, 1'b0, 1'b0, .tgt(8'h20));
        step(3'd4, 8'h50, 2'd1, 1'b0, 1'b0, .tgt(8'h50));
        step(3'd4, 8'h60, 2'd2, 1'b0, 1'b0, .tgt(8'h60));
        step(3'd5, 8'h51, 2'd1, 1'b0, 1'b0);
        step(3'd5, 8'h21, 2'd0, 1'b0, 1'b0);
        step(3'd5, 8'hF0, 2'd0, 1'b1, 1'b0);
        // reset mid call nest empties the stack
        step(3'd0, 8'h00, 2'd0, 1'b0, 1'b0, .rs(1'b1));
        step(3'd4, 8'h50, 2'd1, 1'b0, 1'b0, .tgt(8'h50));
        step(3'd4, 8'h00, 2'd0, 1'b0, 1'b0, .tgt(8'h60), .rs(1'b1));
        step(3'd5, 8'hF0, 2'd0, 1'b1, 1'b0);
        step(3'd5, 8'hF0, 2'd0, 1'b1, 1'b0);
        step(3'd0, 8'h00, 2'd0, 1'b0, 1'b0, .rs(1'b1));
        // memory wait
        step(3'd2, 8'h12, 2'd0, 1'b0, 1'b0, .tgt(8'h12));
        for (int i = 0; i < 4; i++)
            step(3'd6, 8'h12, 2'd0, 1'b0, 1'b0, .mr(1'b0));
        step(3'd6, 8'h13, 2'd0, 1'b0, 1'b0, .mr(1'b1));
        step(3'd6, 8'h13, 2'd0, 1'b0, 1'b0, .mr(1'b0));
        step(3'd6, 8'hF0, 2'd0, 1'b0, 1'b0, .ex(1'b1), .st(1'b1));
        // reset mid wait
        step(3'd2, 8'h12, 2'd0, 1'b0, 1'b0, .tgt(8'h12));
        step(3'd6, 8'h12, 2'd0, 1'b0, 1'b0);
        step(3'd6, 8'h00, 2'd0, 1'b0, 1'b0, .rs(1'b1));
        // fetch then stall: retire drops
        step(3'd2, 8'h33, 2'd0, 1'b0, 1'b0, .tgt(8'h33));
        step(3'd7, 8'h00, 2'd0, 1'b0, 1'b1);
        step(3'd7, 8'h00, 2'd0, 1'b0, 1'b0, .st(1'b1));
        // wrap
        step(3'd2, 8'hFF, 2'd0, 1'b0, 1'b0, .tgt(8'hFF));
        step(3'd0, 8'h00, 2'd0, 1'b0, 1'b0);
        step(3'd3, 8'h01, 2'd0, 1'b0, 1'b0, .cnd(1'b0));

        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        if (n_cmp != n_step) begin
            n_bad++;
            $display("FAIL count: compared %0d, want %0d", n_cmp, n_step);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
